rr_mux_arbiter: RTL and testbench

- Round-robin arbiter sharing one registered output channel between N_REQ valid/ready requesters.
- Grant index drives an N_REQ:1 data select, the same 4-bit-data, 2-bit-select mux used in the combinational section; the winner's data is captured into a one-entry output register.
- Sits in front of any single-consumer sink, for example a shared bus or a FIFO write port, that several producers feed.

---
 rtl/rr_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_mux_arbiter.sv | 69 ++++++
 tb/tb_rr_mux_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and any scheduler reusing rr_pick.
package rr_arb_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned WIDTH_DEF = 4;

   // Modulo-n increment of a requester index; n defaults to the package requester count.
   function automatic int unsigned next_ptr(input int unsigned idx,
                                            input int unsigned n = N_REQ_DEF);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or above i_ptr, wrapping.
module rr_pick #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [ID_W-1:0]  i_ptr,
   input  logic [N_REQ-1:0] i_valid,
   output logic [ID_W-1:0]  o_winner,
   output logic             o_any_valid
);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [ID_W-1:0]    w_off;

   // Duplicating the request vector turns the wrap-around search into a plain shift.
   assign w_dbl = {i_valid, i_valid};
   assign w_rot = N_REQ'(w_dbl >> i_ptr);

   // Lowest set bit of the rotated vector is the distance from ptr to the winner.
   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = ID_W'(i);
      end
   end

   // Index width equals log2(N_REQ), so the sum wraps modulo N_REQ by truncation.
   assign o_winner    = i_ptr + w_off;
   assign o_any_valid = |i_valid;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output slot among N_REQ valid/ready requesters.
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int unsigned N_REQ = N_REQ_DEF,
   parameter  int unsigned WIDTH = WIDTH_DEF,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   in_valid,
   input  logic [N_REQ*WIDTH-1:0] in_data,
   output logic [N_REQ-1:0]   in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [ID_W-1:0]    out_id,
   input  logic               out_ready
);

   logic [ID_W-1:0]  r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [ID_W-1:0]  r_out_id;

   logic [ID_W-1:0]  w_winner;
   logic             w_any_valid;
   logic             w_can_load;
   logic             w_load;
   logic [WIDTH-1:0] w_sel_data;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_ptr       (r_ptr),
      .i_valid     (in_valid),
      .o_winner    (w_winner),
      .o_any_valid (w_any_valid)
   );

   // Output slot can accept when empty or being drained this cycle.
   assign w_can_load = !r_out_valid || out_ready;
   assign w_load     = w_can_load && w_any_valid;
   assign w_sel_data = in_data[w_winner*WIDTH +: WIDTH];

   // Only the current winner sees ready; forced low while reset is held.
   assign in_ready = (w_load && !rst) ? (N_REQ'(1) << w_winner) : '0;

   // Output register and priority pointer; pointer moves past the winner on each accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_id    <= w_winner;
         r_ptr       <= ID_W'(next_ptr(32'(w_winner), N_REQ));
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, async-reset sequence, random vs. model.
module tb_rr_mux_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_id;
   logic           out_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pointer, a one-entry slot, and a modulo search over requesters.
   int       m_ptr;
   bit       m_v;
   bit [3:0] m_d;
   int       m_id;

   function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic r);
      logic [N-1:0] res = '0;
      for (int k = 0; k < N; k++) begin
         int idx = (m_ptr + k) % N;
         if (v[idx]) begin
            res[idx] = (!m_v) || r;
            return res;
         end
      end
      return res;
   endfunction

   task automatic model_update(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
      int  win = -1;
      for (int k = 0; k < N; k++) begin
         int idx = (m_ptr + k) % N;
         if (win < 0 && v[idx]) win = idx;
      end
      if (win >= 0 && (!m_v || r)) begin
         m_d   = d[win*W +: W];
         m_id  = win;
         m_v   = 1'b1;
         m_ptr = (win + 1) % N;
      end else if (m_v && r) begin
         m_v = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_v = 1'b0; m_d = '0; m_id = 0;
   endtask

   // Drive one cycle: inputs set after an edge, ready sampled mid-cycle, outputs sampled after the edge.
   task automatic apply(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r,
                        output logic [N-1:0] rdy);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1 rdy = in_ready;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [15:0] d;
      logic        r;
      logic [3:0]  er;
      logic        ev;
      logic [3:0]  ed;
      logic [1:0]  eid;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [N-1:0] rdy;
      logic [15:0]  rd;
      logic [3:0]   rv;
      logic         rr;
      logic [N-1:0] er;

      // requester i carries data a,b,c,d for i = 0..3
      tbl[0]  = '{4'b0100, 16'hdcba, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2};
      tbl[1]  = '{4'b1111, 16'hdcba, 1'b1, 4'b1000, 1'b1, 4'hd, 2'd3};
      tbl[2]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0};
      tbl[3]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1};
      tbl[4]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2};
      tbl[5]  = '{4'b1111, 16'hdcba, 1'b1, 4'b1000, 1'b1, 4'hd, 2'd3};
      tbl[6]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0};
      tbl[7]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1};
      tbl[8]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2};
      tbl[9]  = '{4'b1001, 16'hdcba, 1'b1, 4'b1000, 1'b1, 4'hd, 2'd3};
      tbl[10] = '{4'b1001, 16'hdcba, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0};
      tbl[11] = '{4'b0010, 16'hdcba, 1'b1, 4'b0010, 1'b1, 4'hb, 2'd1};
      tbl[12] = '{4'b1111, 16'hdcba, 1'b0, 4'b0000, 1'b1, 4'hb, 2'd1};
      tbl[13] = '{4'b1111, 16'hdcba, 1'b0, 4'b0000, 1'b1, 4'hb, 2'd1};
      tbl[14] = '{4'b1111, 16'hdcba, 1'b0, 4'b0000, 1'b1, 4'hb, 2'd1};
      tbl[15] = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 1'b1, 4'hc, 2'd2};
      tbl[16] = '{4'b0000, 16'hdcba, 1'b1, 4'b0000, 1'b0, 4'hc, 2'd2};
      tbl[17] = '{4'b0000, 16'hdcba, 1'b0, 4'b0000, 1'b0, 4'hc, 2'd2};
      tbl[18] = '{4'b1001, 16'hdcba, 1'b0, 4'b1000, 1'b1, 4'hd, 2'd3};

      // Reset state
      rst = 1'b1; in_valid = 4'b1111; in_data = 16'hdcba; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_out_data", 32'(out_data), 32'h0);
      check("reset_out_id", 32'(out_id), 32'h0);
      rst = 1'b0;
      in_valid = '0;

      // Directed vector table
      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].v, tbl[i].d, tbl[i].r, rdy);
         check($sformatf("vec%0d_in_ready", i), 32'(rdy), 32'(tbl[i].er));
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].ed));
         check($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(tbl[i].eid));
      end

      // Async reset while stalled with out_id=1, ptr=2
      apply(4'b0010, 16'hdcba, 1'b1, rdy);
      check("prestall_in_ready", 32'(rdy), 32'h2);
      check("prestall_out_id", 32'(out_id), 32'h1);
      apply(4'b0000, 16'hdcba, 1'b0, rdy);
      check("stall_out_valid", 32'(out_valid), 32'h1);
      #2;
      rst = 1'b1;
      in_valid = 4'b1111;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'h0);
      check("async_rst_out_data", 32'(out_data), 32'h0);
      check("async_rst_out_id", 32'(out_id), 32'h0);
      check("async_rst_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      apply(4'b1111, 16'hdcba, 1'b1, rdy);
      model_update(4'b1111, 16'hdcba, 1'b1);
      check("post_rst_in_ready", 32'(rdy), 32'h1);
      check("post_rst_out_id", 32'(out_id), 32'h0);
      check("post_rst_out_data", 32'(out_data), 32'ha);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         rv = 4'($urandom);
         rd = 16'($urandom);
         rr = ($urandom % 4) != 0;
         er = model_ready(rv, rr);
         apply(rv, rd, rr, rdy);
         model_update(rv, rd, rr);
         check("rand_in_ready", 32'(rdy), 32'(er));
         check("rand_out_valid", 32'(out_valid), 32'(m_v));
         check("rand_out_data", 32'(out_data), 32'(m_d));
         check("rand_out_id", 32'(out_id), 32'(m_id));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
